wb_sevenseg_scan: RTL
=====================

# wb_sevenseg_scan

Wishbone slave that drives the board's four-digit, common-anode seven-segment display on the `anode`/`cathode` pads. It sits downstream of a bus master (CPU or DSP master port) on the bus matrix. Software writes four hex nibbles, decimal points and control bits; the block time-multiplexes the digits with a free-running refresh counter. A new value is latched only at frame boundaries, so the display never tears.

## Interface
- `SLAVE_ADDRESS`, 32'h0: base address; only `wb_adr_i[3:2]` is decoded locally, because the bus matrix performs the base decode.
- `REFRESH_LOG2`, 14: each digit slot lasts 2^REFRESH_LOG2 `wb_clk` cycles; minimum 4.
- `wb_clk` in 1: single clock for the whole block.
- `wb_rst_n` in 1: asynchronous, active-low reset.
- `wb_adr_i` in 32: byte address.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte enables; honoured on writes.
- `wb_we_i` in 1: write enable.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_dat_o` out 32: read data.
- `wb_ack_o` out 1: transfer acknowledge.
- `wb_err_o` out 1: error, asserted instead of ack.
- `wb_rty_o` out 1: tied 0.
- `anode` out 4: digit enables, active low; `anode[0]` is the rightmost digit.
- `cathode` out 8: segments, active low; `[0]`=a … `[6]`=g, `[7]`=dp.

## Operation
- Registers, selected by `adr[3:2]`:
  - 0 CTRL: bit0 EN, bits[7:4] BRIGHT.
  - 1 VALUE: bits[15:0], one nibble per digit; digit k = `[4k+3:4k]`.
  - 2 DP: bits[3:0], one per digit; 1 lights the dp.
  - 3 STATUS (read-only): bits[1:0] current digit, bit8 set when VALUE/DP differ from the frame shadow.
  - Unused bits read 0.
- A write to STATUS is answered with `wb_err_o` instead of ack, and nothing changes. Reads never error.
- Refresh counter `pre`, REFRESH_LOG2 bits, runs whenever the block is out of reset (regardless of EN). When `pre` reaches all-ones, digit index `dig` increments mod 4.
- Shadow VALUE/DP are loaded from the registers on the cycle `dig` wraps 3→0. A frame therefore always shows one coherent value.
- Hex decode into cathode bits [6:0]: 0→7'b1000000, 1→7'b1111001, 8→7'b0000000, F→7'b0001110, with standard patterns for the rest. `cathode[7]` = ~shadow_dp[dig].
- EN=0: `anode`=4'hF and `cathode`=8'hFF; the counters keep running.
- EN=1: `anode` = ~(1<<dig), gated by brightness (see Configuration).

## Timing
- Reset values:
  - Outputs: `anode` 4'hF, `cathode` 8'hFF, `wb_ack_o`/`wb_err_o` 0, `wb_dat_o` 0.
  - State: CTRL 0, VALUE 0, DP 0, shadows 0, `pre` 0, `dig` 0.
- Bus handshake: when `cyc&stb` is seen with no ack/err already asserted at cycle N, the block asserts ack (or err) for exactly one cycle at N+1. `wb_dat_o` is valid at N+1.
- A master holding `stb` after the response gets a fresh response every second cycle; there are no back-to-back acks.
- A write is visible to a read one cycle after its ack. It reaches the display at the next 3→0 wrap.
- `anode`/`cathode` are registered and lag `pre`/`dig` by one cycle. Anode and cathode change on the same edge.
- If reset is asserted mid-transfer, the ack is dropped immediately and no write is committed. If reset is asserted mid-frame, the display blanks immediately.
- Simultaneous VALUE write and 3→0 wrap: the shadow takes the old value; the new value appears in the next frame.

## Configuration
- `SEVENSEG_BRIGHTNESS_EN` defined:
  - The anode is on only while `pre[REFRESH_LOG2-1 -: 4] <= BRIGHT`.
  - BRIGHT=15 gives full duty; BRIGHT=0 gives 1/16 duty.
  - CTRL[7:4] is read/write.
- Undefined: the anode is on for the whole slot, and CTRL[7:4] is read-only 0 (writes to it are ignored).

## Structure
- Shared package `sevenseg_pkg`: register word offsets (CTRL/VALUE/DP/STATUS), bit positions of EN and BRIGHT, and the 16-entry segment pattern constants.
- One sub-module, `sevenseg_decode`: combinational 4-bit nibble plus dp → 8-bit active-low cathode.

## Test plan
All scenarios run with the bench at REFRESH_LOG2=4.
- Reset, then idle 100 cycles → `anode`=4'hF, `cathode`=8'hFF, and no ack.
- Write VALUE=32'h0000_1208, DP=4'b0001, CTRL=1 → after the next wrap, the digit0 slot shows `anode`=4'b1110, `cathode`=8'b0000_0000; digit1 shows 8'b1100_0000; digit3 shows 8'b1111_1001.
- Write VALUE mid-frame → STATUS bit8 reads 1 until the wrap. The old pattern holds until `dig` returns to 0, then the new pattern appears.
- Write STATUS → `wb_err_o` pulses for 1 cycle, `wb_ack_o` stays 0, and registers are unchanged. A write to VALUE with `sel`=4'b0001 changes only bits[7:0].
- With the macro, BRIGHT=3 → the anode is low for exactly 4 of every 16 cycles per slot. Without the macro, CTRL reads back 32'h1 after writing 32'hF1.
- Deassert `wb_rst_n` during a held `stb` write → no ack and VALUE remains 0. After release, the next transfer acks at N+1.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared register map and segment patterns for the seven-segment scanner.
// Active-low segment patterns, index = hex digit, bit order {g,f,e,d,c,b,a}.
package sevenseg_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_VALUE  = 2'd1;
  localparam logic [1:0] REG_DP     = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_BRIGHT_LSB = 4;
  localparam int STATUS_DIRTY    = 8;

  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/sevenseg_decode.sv
// Nibble plus decimal point to active-low cathode pattern.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] cathode
);

  assign cathode = {~dp, SEG_TABLE[nibble]};

endmodule

// File: rtl/wb_sevenseg_scan.sv
// Wishbone four-digit seven-segment scanner with frame-coherent shadows.
// Optional PWM brightness via SEVENSEG_BRIGHTNESS_EN.
module wb_sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter logic [31:0] SLAVE_ADDRESS = 32'h0,
  parameter int          REFRESH_LOG2  = 14
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic [3:0]  anode,
  output logic [7:0]  cathode
);

  logic [REFRESH_LOG2-1:0] pre_q, pre_d;
  logic [1:0]  dig_q, dig_d;
  logic        en_q, en_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  dp_q, dp_d;
  logic [15:0] sh_value_q, sh_value_d;
  logic [3:0]  sh_dp_q, sh_dp_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  anode_q, anode_d;
  logic [7:0]  cathode_q, cathode_d;
  logic [3:0]  bright;
  logic        duty_on;
  logic        req, wr, wr_ok, frame_wrap, dirty;
  logic [1:0]  reg_sel;
  logic [31:0] rdata;
  logic [7:0]  seg;
  logic        unused_ok;

`ifdef SEVENSEG_BRIGHTNESS_EN
  logic [3:0] bright_q, bright_d;
  assign bright  = bright_q;
  assign duty_on = pre_q[REFRESH_LOG2-1 -: 4] <= bright_q;
`else
  assign bright  = 4'h0;
  assign duty_on = 1'b1;
`endif

  sevenseg_decode u_dec (
    .nibble  (sh_value_q[{dig_q, 2'b00} +: 4]),
    .dp      (sh_dp_q[dig_q]),
    .cathode (seg)
  );

  always_comb begin
    reg_sel    = wb_adr_i[3:2];
    req        = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    wr         = req & wb_we_i;
    wr_ok      = wr & (reg_sel != REG_STATUS);
    frame_wrap = (&pre_q) & (dig_q == 2'd3);
    dirty      = (value_q != sh_value_q) | (dp_q != sh_dp_q);
    rdata      = '0;
    unique case (reg_sel)
      REG_CTRL:  rdata = {24'h0, bright, 3'b000, en_q};
      REG_VALUE: rdata = {16'h0, value_q};
      REG_DP:    rdata = {28'h0, dp_q};
      default: begin
        rdata[STATUS_DIRTY] = dirty;
        rdata[1:0]          = dig_q;
      end
    endcase
  end

  always_comb begin
    pre_d   = pre_q + 1'b1;
    dig_d   = (&pre_q) ? dig_q + 2'd1 : dig_q;
    en_d    = en_q;
    value_d = value_q;
    dp_d    = dp_q;
`ifdef SEVENSEG_BRIGHTNESS_EN
    bright_d = bright_q;
`endif
    if (wr_ok) begin
      unique case (reg_sel)
        REG_CTRL: if (wb_sel_i[0]) begin
          en_d = wb_dat_i[CTRL_EN_BIT];
`ifdef SEVENSEG_BRIGHTNESS_EN
          bright_d = wb_dat_i[CTRL_BRIGHT_LSB +: 4];
`endif
        end
        REG_VALUE: begin
          if (wb_sel_i[0]) value_d[7:0]  = wb_dat_i[7:0];
          if (wb_sel_i[1]) value_d[15:8] = wb_dat_i[15:8];
        end
        REG_DP: if (wb_sel_i[0]) dp_d = wb_dat_i[3:0];
        default: ;
      endcase
    end
    // shadows sample the pre-write registers, so a racing write waits a frame
    sh_value_d = frame_wrap ? value_q : sh_value_q;
    sh_dp_d    = frame_wrap ? dp_q : sh_dp_q;
    ack_d      = req & ~(wb_we_i & (reg_sel == REG_STATUS));
    err_d      = wr & ~wr_ok;
    dat_d      = (req & ~wb_we_i) ? rdata : '0;
    anode_d    = (en_q & duty_on) ? ~(4'b0001 << dig_q) : 4'hF;
    cathode_d  = en_q ? seg : 8'hFF;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      pre_q      <= '0;
      dig_q      <= '0;
      en_q       <= 1'b0;
      value_q    <= '0;
      dp_q       <= '0;
      sh_value_q <= '0;
      sh_dp_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      anode_q    <= 4'hF;
      cathode_q  <= 8'hFF;
`ifdef SEVENSEG_BRIGHTNESS_EN
      bright_q   <= '0;
`endif
    end else begin
      pre_q      <= pre_d;
      dig_q      <= dig_d;
      en_q       <= en_d;
      value_q    <= value_d;
      dp_q       <= dp_d;
      sh_value_q <= sh_value_d;
      sh_dp_q    <= sh_dp_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      anode_q    <= anode_d;
      cathode_q  <= cathode_d;
`ifdef SEVENSEG_BRIGHTNESS_EN
      bright_q   <= bright_d;
`endif
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
  assign anode    = anode_q;
  assign cathode  = cathode_q;

  assign unused_ok = ^{SLAVE_ADDRESS, wb_adr_i[31:4], wb_adr_i[1:0],
                       wb_dat_i[31:16], wb_sel_i[3:2]};

endmodule
